stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Controller that sequences the millisecond pulse generator for the board stopwatch.
- Turns debounced single-cycle button pulses into start/stop commands for the generator.
- Counts the generator's millisecond pulses into a 4-digit BCD time SS.cc (seconds, centiseconds) for the seven-segment driver.
- Freezes the display for lap readout while counting continues.

Parameters:
- TICKS_PER_CS, 10, ms pulses per centisecond; legal 1..255.
- PRESC_W, 8, prescaler width; must satisfy 2^PRESC_W > TICKS_PER_CS.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- btn_ss  in  1  start/stop request; one-cycle pulse, already debounced
- btn_lap  in  1  lap request; one-cycle pulse
- btn_clr  in  1  clear request; one-cycle pulse
- ms_tick  in  1  generator pulse output; level, high for multiple cycles per ms
- gen_start  out  1  one-cycle start pulse to the generator
- gen_stop  out  1  level stop to the generator; high whenever not counting
- running  out  1  high in RUNNING and LAP
- digit3..digit0  out  4 each  BCD display: sec tens, sec ones, cs tens, cs ones
- wrapped  out  1  sticky; set when time rolls 99.99 -> 00.00

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE; prescaler, live time and lap time all 0.
  - gen_start=0, gen_stop=1, running=0, wrapped=0, edge register=0.
  - Applies identically mid-run.
- Tick detection:
  - ms_tick is registered into ms_q.
  - tick_rise = ms_tick & ~ms_q.
  - Exactly one count per generator pulse, regardless of how long ms_tick stays high.
- Counting (only while state is RUNNING or LAP at the clock edge):
  - Each tick_rise increments the prescaler.
  - When the prescaler reaches TICKS_PER_CS-1 it returns to 0 and the live time advances 1 cs.
  - Cascaded BCD digits, each 0..9, carry upward; digit3 also 0..9.
  - 99.99 + 1 cs -> 00.00 and sets wrapped; counting continues.
  - Digits update on the same edge that samples tick_rise, i.e. visible the cycle after ms_tick is first seen high.
- States and transitions (button priority clr > ss > lap; at most one action per cycle):
  - IDLE, btn_ss: go to RUNNING; assert gen_start for 1 cycle and drop gen_stop on the same edge.
  - IDLE, btn_clr: clear wrapped; stay in IDLE.
  - IDLE, btn_lap: ignored.
  - RUNNING, btn_ss: go to PAUSED; gen_stop=1.
  - RUNNING, btn_lap: copy live time into lap register; go to LAP.
  - RUNNING, btn_clr: ignored.
  - LAP, btn_lap: go to RUNNING; display returns to live time.
  - LAP, btn_ss: go to PAUSED; display shows live time.
  - LAP, btn_clr: ignored.
  - PAUSED, btn_ss: go to RUNNING; gen_start pulse.
  - PAUSED, btn_clr: go to IDLE; live time, prescaler and wrapped all cleared.
  - PAUSED, btn_lap: ignored.
- Display mux: digits = lap register in LAP, live time otherwise.
- All outputs registered.
- Simultaneous events:
  - tick_rise in the same cycle as a pause request is counted, because the state is still RUNNING at that edge.
  - tick_rise in the same cycle as a resume is not counted.
- Prescaler is held (not cleared) on pause, so resume keeps sub-cs phase.
- Generator phase is not cleared by stop; first interval after start may be short, and the controller does not compensate.

Optional Feature:
- Macro STOPWATCH_SPLIT_EN.
- Defined: while in LAP, a further btn_lap pulse with btn_ss low re-captures the lap register (new split) and stays in LAP. Exit from LAP is only via btn_ss (to PAUSED).
- Undefined: LAP behaves exactly as described in Behaviour (btn_lap returns to RUNNING).

Test Plan:
- Reset with TICKS_PER_CS=2 -> digits 0000, gen_stop=1, gen_start=0, running=0; hold rst 3 cycles mid-run -> same values.
- btn_ss, then 2 ms_tick pulses each high 5 cycles -> one gen_start pulse, gen_stop low; digits 0001 only after the second rise; long high level adds no extra count.
- Run to 99.99, then 2 more rises -> digits 0000, wrapped=1; pause then btn_clr -> IDLE, wrapped=0, digits 0000.
- Running at 00.05, btn_lap, then 4 rises -> digits stay 0005, running=1; btn_lap -> digits 0007.
- Running, btn_ss coincident with a completing tick_rise -> that tick counted, state PAUSED; btn_ss coincident with a rise -> not counted; btn_clr while RUNNING -> ignored.
- STOPWATCH_SPLIT_EN defined: lap at 00.03, 2 rises, btn_lap -> display 0004, still LAP; btn_ss -> PAUSED, live digits shown.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear sequencing of the ms generator
// and a BCD SS.cc time counter; STOPWATCH_SPLIT_EN enables repeated splits.
module stopwatch_ctrl #(
  parameter int TICKS_PER_CS = 10,
  parameter int PRESC_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       ms_tick,
  output logic       gen_start,
  output logic       gen_stop,
  output logic       running,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       wrapped
);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    LAP,
    PAUSED
  } state_t;

  localparam logic [PRESC_W-1:0] LAST =
    PRESC_W'(TICKS_PER_CS - 1);

  state_t             state, state_n;
  logic               ms_q;
  logic               tick_rise;
  logic               counting;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [15:0]        live, live_n;
  logic [15:0]        lap, lap_n;
  logic [15:0]        disp;
  logic               wrapped_n;
  logic               start_n;
  logic               run_n;

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick_rise = ms_tick & ~ms_q;
  assign counting  = (state == RUNNING) || (state == LAP);

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    live_n    = live;
    lap_n     = lap;
    wrapped_n = wrapped;
    start_n   = 1'b0;

    if (counting && tick_rise) begin
      if (presc == LAST) begin
        presc_n = '0;
        live_n  = bcd_inc(live);
        if (live == 16'h9999)
          wrapped_n = 1'b1;
      end else begin
        presc_n = presc + 1'b1;
      end
    end

    // each state only looks at the buttons it reacts to, highest first
    case (state)
      IDLE: begin
        priority case (1'b1)
          btn_clr: wrapped_n = 1'b0;
          btn_ss: begin
            state_n = RUNNING;
            start_n = 1'b1;
          end
          default: ;
        endcase
      end
      RUNNING: begin
        priority case (1'b1)
          btn_ss: state_n = PAUSED;
          btn_lap: begin
            lap_n   = live;
            state_n = LAP;
          end
          default: ;
        endcase
      end
      LAP: begin
        priority case (1'b1)
          btn_ss: state_n = PAUSED;
`ifdef STOPWATCH_SPLIT_EN
          btn_lap: lap_n = live;
`else
          btn_lap: state_n = RUNNING;
`endif
          default: ;
        endcase
      end
      PAUSED: begin
        priority case (1'b1)
          btn_clr: begin
            state_n   = IDLE;
            live_n    = '0;
            presc_n   = '0;
            wrapped_n = 1'b0;
          end
          btn_ss: begin
            state_n = RUNNING;
            start_n = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  assign run_n = (state_n == RUNNING) || (state_n == LAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ms_q      <= 1'b0;
      presc     <= '0;
      live      <= '0;
      lap       <= '0;
      disp      <= '0;
      wrapped   <= 1'b0;
      gen_start <= 1'b0;
      gen_stop  <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_n;
      ms_q      <= ms_tick;
      presc     <= presc_n;
      live      <= live_n;
      lap       <= lap_n;
      disp      <= (state_n == LAP) ? lap_n : live_n;
      wrapped   <= wrapped_n;
      gen_start <= start_n;
      gen_stop  <= ~run_n;
      running   <= run_n;
    end
  end

  assign digit3 = disp[15:12];
  assign digit2 = disp[11:8];
  assign digit1 = disp[7:4];
  assign digit0 = disp[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICKS_PER_CS=2.
// Define STOPWATCH_SPLIT_EN to also exercise the split path.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       ms_tick;
  logic       gen_start;
  logic       gen_stop;
  logic       running;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       wrapped;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .TICKS_PER_CS(2),
    .PRESC_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_ss(btn_ss),
    .btn_lap(btn_lap),
    .btn_clr(btn_clr),
    .ms_tick(ms_tick),
    .gen_start(gen_start),
    .gen_stop(gen_stop),
    .running(running),
    .digit3(digit3),
    .digit2(digit2),
    .digit1(digit1),
    .digit0(digit0),
    .wrapped(wrapped)
  );

  always #10 clk = ~clk;

  wire [15:0] digits = {digit3, digit2, digit1, digit0};

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    btn_ss = 1'b1;
    cyc();
    btn_ss = 1'b0;
  endtask

  task automatic press_lap();
    btn_lap = 1'b1;
    cyc();
    btn_lap = 1'b0;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    cyc();
    btn_clr = 1'b0;
  endtask

  task automatic tick(input int hi, input int lo);
    ms_tick = 1'b1;
    repeat (hi) cyc();
    ms_tick = 1'b0;
    repeat (lo) cyc();
  endtask

  initial begin
    rst     = 1'b1;
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    btn_clr = 1'b0;
    ms_tick = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_stop", 32'(gen_stop), 1);
    chk("rst_start", 32'(gen_start), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_wrap", 32'(wrapped), 0);

    press_lap();
    chk("idle_lap", 32'(running), 0);

    press_ss();
    chk("start_pulse", 32'(gen_start), 1);
    chk("start_stop", 32'(gen_stop), 0);
    chk("start_run", 32'(running), 1);
    cyc();
    chk("start_1cyc", 32'(gen_start), 0);

    tick(5, 2);
    chk("first_rise", 32'(digits), 32'h0000);
    ms_tick = 1'b1;
    cyc();
    chk("second_rise", 32'(digits), 32'h0001);
    repeat (4) cyc();
    ms_tick = 1'b0;
    cyc();
    chk("long_high", 32'(digits), 32'h0001);

    repeat (8) tick(1, 1);
    chk("at_0005", 32'(digits), 32'h0005);
    press_lap();
    chk("lap_enter", 32'(digits), 32'h0005);
    repeat (4) tick(2, 1);
    chk("lap_frozen", 32'(digits), 32'h0005);
    chk("lap_run", 32'(running), 1);
    press_lap();
    chk("lap_exit", 32'(digits), 32'h0007);
    chk("lap_exit_run", 32'(running), 1);
    repeat (2) tick(1, 1);
`ifdef STOPWATCH_SPLIT_EN
    chk("split_hold", 32'(digits), 32'h0007);
    press_lap();
    chk("split_new", 32'(digits), 32'h0008);
    chk("split_run", 32'(running), 1);
    press_ss();
    chk("split_pause", 32'(digits), 32'h0008);
    chk("split_paused", 32'(running), 0);
    press_ss();
    chk("split_resume", 32'(gen_start), 1);
`else
    chk("run_0008", 32'(digits), 32'h0008);
`endif

    tick(1, 1);
    chk("half_cs", 32'(digits), 32'h0008);
    ms_tick = 1'b1;
    btn_ss  = 1'b1;
    cyc();
    btn_ss  = 1'b0;
    chk("pause_tick", 32'(digits), 32'h0009);
    chk("pause_run", 32'(running), 0);
    chk("pause_stop", 32'(gen_stop), 1);
    ms_tick = 1'b0;
    cyc();

    ms_tick = 1'b1;
    btn_ss  = 1'b1;
    cyc();
    btn_ss  = 1'b0;
    chk("resume_start", 32'(gen_start), 1);
    chk("resume_tick", 32'(digits), 32'h0009);
    repeat (2) cyc();
    ms_tick = 1'b0;
    cyc();
    tick(1, 1);
    chk("resume_phase", 32'(digits), 32'h0009);
    tick(1, 1);
    chk("resume_adv", 32'(digits), 32'h0010);

    press_clr();
    chk("run_clr", 32'(digits), 32'h0010);
    chk("run_clr_run", 32'(running), 1);

    rst = 1'b1;
    ms_tick = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    ms_tick = 1'b0;
    chk("mid_rst_dig", 32'(digits), 32'h0000);
    chk("mid_rst_stop", 32'(gen_stop), 1);
    chk("mid_rst_run", 32'(running), 0);
    chk("mid_rst_start", 32'(gen_start), 0);
    cyc();

    press_ss();
    repeat (19998) tick(1, 1);
    chk("at_9999", 32'(digits), 32'h9999);
    chk("pre_wrap", 32'(wrapped), 0);
    repeat (2) tick(1, 1);
    chk("wrap_dig", 32'(digits), 32'h0000);
    chk("wrap_flag", 32'(wrapped), 1);
    chk("wrap_run", 32'(running), 1);
    tick(1, 1);
    tick(1, 1);
    chk("wrap_cont", 32'(digits), 32'h0001);

    press_ss();
    press_clr();
    chk("clr_wrap", 32'(wrapped), 0);
    chk("clr_dig", 32'(digits), 32'h0000);
    chk("clr_run", 32'(running), 0);
    chk("clr_stop", 32'(gen_stop), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
